// File: rtl/elevator_car_model.sv
// elevator_car_model: car/shaft/door plant model driven by controller motor and door commands
module elevator_car_model #(
    parameter int NUM_FLOORS    = 4,
    parameter int FLOOR_W       = 2,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               motor_up,
    input  logic               motor_down,
    input  logic               door_open,
    output logic [FLOOR_W-1:0] floor,
    output logic               at_floor,
    output logic               moving,
    output logic               door_closed,
    output logic               door_fully_open,
    output logic               fault
);
    localparam int TW = $clog2(TRAVEL_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);
    localparam logic [TW-1:0] T_END = TW'(TRAVEL_CYCLES);
    localparam logic [DW-1:0] D_END = DW'(DOOR_CYCLES);
    localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(NUM_FLOORS - 1);

    typedef enum logic [2:0] {
        IDLE, MOVE_UP, MOVE_DN, DOOR_OPENING, DOOR_OPEN, DOOR_CLOSING, FAULT
    } state_t;

    state_t state_q, state_d;
    logic [TW-1:0] travel_cnt_q, travel_cnt_d;
    logic [DW-1:0] door_cnt_q, door_cnt_d;
    logic [FLOOR_W-1:0] floor_q, floor_d, next_floor, end_floor;
    logic at_floor_q, at_floor_d, moving_q, moving_d;
    logic door_closed_q, door_closed_d, door_fully_open_q, door_fully_open_d;
    logic fault_q, fault_d;
    logic up_dir, same_cmd, opp_cmd, any_motor, go_fault;

    always_comb begin
        state_d           = state_q;
        travel_cnt_d      = travel_cnt_q;
        door_cnt_d        = door_cnt_q;
        floor_d           = floor_q;
        at_floor_d        = at_floor_q;
        moving_d          = moving_q;
        door_closed_d     = door_closed_q;
        door_fully_open_d = door_fully_open_q;
        fault_d           = fault_q;
        go_fault          = 1'b0;
        up_dir            = state_q == MOVE_UP;
        same_cmd          = up_dir ? motor_up : motor_down;
        opp_cmd           = up_dir ? motor_down : motor_up;
        any_motor         = motor_up | motor_down;
        next_floor        = up_dir ? floor_q + 1'b1 : floor_q - 1'b1;
        end_floor         = up_dir ? TOP : '0;
        case (state_q)
            IDLE: begin
                if ((motor_up & motor_down) | (any_motor & door_open)
                    | (motor_up & floor_q == TOP) | (motor_down & floor_q == '0)) begin
                    go_fault = 1'b1;
                end else if (any_motor) begin
                    state_d      = motor_up ? MOVE_UP : MOVE_DN;
                    moving_d     = 1'b1;
                    at_floor_d   = 1'b0;
                    travel_cnt_d = TW'(1);
                end else if (door_open) begin
                    state_d       = DOOR_OPENING;
                    door_closed_d = 1'b0;
                    door_cnt_d    = DW'(1);
                end
            end
            MOVE_UP, MOVE_DN: begin
                if (opp_cmd | door_open) begin
                    go_fault = 1'b1;
                end else if (travel_cnt_q == T_END) begin
                    floor_d    = next_floor;
                    at_floor_d = 1'b1;
                    // continuing travel reloads the counter so every leg takes TRAVEL_CYCLES edges
                    if (same_cmd && next_floor != end_floor) begin
                        travel_cnt_d = TW'(1);
                    end else begin
                        state_d      = IDLE;
                        moving_d     = 1'b0;
                        travel_cnt_d = '0;
                    end
                end else begin
                    travel_cnt_d = travel_cnt_q + 1'b1;
                    at_floor_d   = 1'b0;
                end
            end
            DOOR_OPENING: begin
                if (any_motor) begin
                    go_fault = 1'b1;
                end else if (!door_open) begin
                    state_d    = DOOR_CLOSING;
                    door_cnt_d = DW'(1);
                end else if (door_cnt_q == D_END) begin
                    state_d           = DOOR_OPEN;
                    door_fully_open_d = 1'b1;
                    door_cnt_d        = '0;
                end else begin
                    door_cnt_d = door_cnt_q + 1'b1;
                end
            end
            DOOR_OPEN: begin
                if (any_motor) begin
                    go_fault = 1'b1;
                end else if (!door_open) begin
                    state_d           = DOOR_CLOSING;
                    door_fully_open_d = 1'b0;
                    door_cnt_d        = DW'(1);
                end
            end
            DOOR_CLOSING: begin
                if (any_motor) begin
                    go_fault = 1'b1;
                end else if (door_open) begin
                    state_d    = DOOR_OPENING;
                    door_cnt_d = DW'(1);
                end else if (door_cnt_q == D_END) begin
                    state_d       = IDLE;
                    door_closed_d = 1'b1;
                    door_cnt_d    = '0;
                end else begin
                    door_cnt_d = door_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
        // a violation freezes position and door outputs at their present values
        if (go_fault) begin
            state_d           = FAULT;
            fault_d           = 1'b1;
            moving_d          = 1'b0;
            floor_d           = floor_q;
            at_floor_d        = at_floor_q;
            door_closed_d     = door_closed_q;
            door_fully_open_d = door_fully_open_q;
            travel_cnt_d      = travel_cnt_q;
            door_cnt_d        = door_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            travel_cnt_q      <= '0;
            door_cnt_q        <= '0;
            floor_q           <= '0;
            at_floor_q        <= 1'b1;
            moving_q          <= 1'b0;
            door_closed_q     <= 1'b1;
            door_fully_open_q <= 1'b0;
            fault_q           <= 1'b0;
        end else begin
            state_q           <= state_d;
            travel_cnt_q      <= travel_cnt_d;
            door_cnt_q        <= door_cnt_d;
            floor_q           <= floor_d;
            at_floor_q        <= at_floor_d;
            moving_q          <= moving_d;
            door_closed_q     <= door_closed_d;
            door_fully_open_q <= door_fully_open_d;
            fault_q           <= fault_d;
        end
    end

    assign floor           = floor_q;
    assign at_floor        = at_floor_q;
    assign moving          = moving_q;
    assign door_closed     = door_closed_q;
    assign door_fully_open = door_fully_open_q;
    assign fault           = fault_q;
endmodule

// File: tb/tb_elevator_car_model.sv
// tb_elevator_car_model: directed checks of car travel, door timing and fault latching
module tb_elevator_car_model;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic motor_up = 1'b0, motor_down = 1'b0, door_open = 1'b0;
    logic [1:0] floor;
    logic at_floor, moving, door_closed, door_fully_open, fault;
    logic [6:0] o;
    int pass_cnt = 0;
    int total_cnt = 0;

    // output vector: {floor, at_floor, moving, door_closed, door_fully_open, fault}
    localparam logic [4:0] IDL = 5'b10100;
    localparam logic [4:0] TRV = 5'b01100;
    localparam logic [4:0] ARR = 5'b11100;
    localparam logic [4:0] DMV = 5'b10000;
    localparam logic [4:0] DOP = 5'b10010;

    elevator_car_model dut (
        .clk(clk), .reset(reset), .motor_up(motor_up), .motor_down(motor_down),
        .door_open(door_open), .floor(floor), .at_floor(at_floor), .moving(moving),
        .door_closed(door_closed), .door_fully_open(door_fully_open), .fault(fault)
    );

    always #5 clk = ~clk;
    assign o = {floor, at_floor, moving, door_closed, door_fully_open, fault};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        {motor_up, motor_down, door_open} = 3'b000;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        if (o !== {2'd0, IDL}) $display("FAIL reset_edge got %b exp %b", o, {2'd0, IDL});
        else pass_cnt++;
        total_cnt++;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o !== {2'd0, IDL}) $display("FAIL reset_idle[%0d] got %b exp %b", i, o, {2'd0, IDL});
            else pass_cnt++;
            total_cnt++;
        end
    endtask

    task automatic test_travel();
        logic [6:0] exp_t [9];
        exp_t = '{{2'd0, TRV}, {2'd0, TRV}, {2'd0, TRV}, {2'd0, TRV}, {2'd1, ARR},
                  {2'd1, TRV}, {2'd1, TRV}, {2'd1, TRV}, {2'd2, IDL}};
        do_reset();
        motor_up = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (o !== exp_t[i]) $display("FAIL travel_up[%0d] got %b exp %b", i, o, exp_t[i]);
            else pass_cnt++;
            total_cnt++;
            if (i == 6) motor_up = 1'b0;
        end
        tick();
        if (o !== {2'd2, IDL}) $display("FAIL travel_settle got %b exp %b", o, {2'd2, IDL});
        else pass_cnt++;
        total_cnt++;
        motor_down = 1'b1;
        tick();
        motor_down = 1'b0;
        if (o !== {2'd2, TRV}) $display("FAIL travel_dn_start got %b exp %b", o, {2'd2, TRV});
        else pass_cnt++;
        total_cnt++;
        repeat (3) tick();
        if (o !== {2'd2, TRV}) $display("FAIL travel_dn_coast got %b exp %b", o, {2'd2, TRV});
        else pass_cnt++;
        total_cnt++;
        tick();
        if (o !== {2'd1, IDL}) $display("FAIL travel_dn_arrive got %b exp %b", o, {2'd1, IDL});
        else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_door();
        logic [6:0] exp_d [10];
        exp_d = '{{2'd0, DMV}, {2'd0, DMV}, {2'd0, DMV}, {2'd0, DOP}, {2'd0, DOP},
                  {2'd0, DOP}, {2'd0, DMV}, {2'd0, DMV}, {2'd0, DMV}, {2'd0, IDL}};
        do_reset();
        door_open = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 6) door_open = 1'b0;
            tick();
            if (o !== exp_d[i]) $display("FAIL door[%0d] got %b exp %b", i, o, exp_d[i]);
            else pass_cnt++;
            total_cnt++;
        end
    endtask

    task automatic test_door_reversal();
        logic [6:0] exp_r [6];
        exp_r = '{{2'd0, DMV}, {2'd0, DMV}, {2'd0, DMV}, {2'd0, DMV}, {2'd0, DMV}, {2'd0, DOP}};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            door_open = (i != 1);
            tick();
            if (o !== exp_r[i]) $display("FAIL door_rev[%0d] got %b exp %b", i, o, exp_r[i]);
            else pass_cnt++;
            total_cnt++;
        end
        door_open = 1'b0;
    endtask

    task automatic fault_hold(input string name, input logic [6:0] exp);
        int bad = 0;
        for (int i = 0; i < 20; i++) begin
            {motor_up, motor_down, door_open} = 3'($urandom);
            tick();
            if (o !== exp) bad++;
        end
        if (bad != 0) $display("FAIL %s_hold got %0d bad cycles exp 0 (last %b exp %b)", name, bad, o, exp);
        else pass_cnt++;
        total_cnt++;
        do_reset();
        if (o !== {2'd0, IDL}) $display("FAIL %s_clear got %b exp %b", name, o, {2'd0, IDL});
        else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_fault_both();
        do_reset();
        {motor_up, motor_down} = 2'b11;
        tick();
        if (o !== 7'b00_10101) $display("FAIL fault_both got %b exp %b", o, 7'b00_10101);
        else pass_cnt++;
        total_cnt++;
        fault_hold("fault_both", 7'b00_10101);
    endtask

    task automatic test_fault_floor0();
        do_reset();
        motor_down = 1'b1;
        tick();
        if (o !== 7'b00_10101) $display("FAIL fault_dn0 got %b exp %b", o, 7'b00_10101);
        else pass_cnt++;
        total_cnt++;
        fault_hold("fault_dn0", 7'b00_10101);
    endtask

    task automatic test_fault_door();
        do_reset();
        door_open = 1'b1;
        repeat (4) tick();
        if (o !== {2'd0, DOP}) $display("FAIL fault_door_pre got %b exp %b", o, {2'd0, DOP});
        else pass_cnt++;
        total_cnt++;
        motor_up = 1'b1;
        tick();
        if (o !== 7'b00_10011) $display("FAIL fault_door got %b exp %b", o, 7'b00_10011);
        else pass_cnt++;
        total_cnt++;
        fault_hold("fault_door", 7'b00_10011);
    endtask

    task automatic test_reset_mid_travel();
        do_reset();
        for (int f = 1; f <= 2; f++) begin
            motor_up = 1'b1;
            tick();
            motor_up = 1'b0;
            repeat (4) tick();
            if (o !== {2'(f), IDL}) $display("FAIL rst_mid_climb[%0d] got %b exp %b", f, o, {2'(f), IDL});
            else pass_cnt++;
            total_cnt++;
        end
        motor_up = 1'b1;
        repeat (2) tick();
        if (o !== {2'd2, TRV}) $display("FAIL rst_mid_moving got %b exp %b", o, {2'd2, TRV});
        else pass_cnt++;
        total_cnt++;
        reset = 1'b1;
        tick();
        if (o !== {2'd0, IDL}) $display("FAIL rst_mid_edge got %b exp %b", o, {2'd0, IDL});
        else pass_cnt++;
        total_cnt++;
        reset = 1'b0;
        tick();
        motor_up = 1'b0;
        if (o !== {2'd0, TRV}) $display("FAIL rst_mid_restart got %b exp %b", o, {2'd0, TRV});
        else pass_cnt++;
        total_cnt++;
        repeat (4) tick();
        if (o !== {2'd1, IDL}) $display("FAIL rst_mid_arrive got %b exp %b", o, {2'd1, IDL});
        else pass_cnt++;
        total_cnt++;
    endtask

    initial begin
        test_reset();
        test_travel();
        test_door();
        test_door_reversal();
        test_fault_both();
        test_fault_floor0();
        test_fault_door();
        test_reset_mid_travel();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
